multimode_ring_mod: RTL
=======================

MULTIMODE_RING_MOD -- requirements
Module: multimode_ring_mod

Interface
REQ-001 Parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 Parameter PHASE_W, default 24: carrier phase accumulator width; SHALL be >= DATA_W.
REQ-003 Parameter MIX_W, default 8: wet/dry mix control width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  audio clock (clk_pdm domain); all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  1 = effect active; 0 = dry pass-through with phase held.
REQ-008 mode  input  2  carrier shape: 00 square, 01 triangle, 10 sawtooth, 11 bypass.
REQ-009 phase_inc  input  PHASE_W  phase added per clk; carrier freq = f_clk*phase_inc/2^PHASE_W.
REQ-010 mix  input  MIX_W  wet weight; 0 = all dry, all-ones = all wet.
REQ-011 in_valid  input  1  pcm_in qualifier; no backpressure.
REQ-012 pcm_in  input  DATA_W  signed input sample.
REQ-013 out_valid  output  1  one-cycle pulse per accepted sample.
REQ-014 pcm_out  output  DATA_W  signed output sample; held between pulses.

Function
REQ-015 Phase register ph SHALL update ph <= ph + phase_inc (mod 2^PHASE_W) each cycle enable=1, and hold when enable=0.
REQ-016 P = ph[PHASE_W-1 -: DATA_W] (unsigned); MAX = 2^(DATA_W-1)-1; carrier c is signed DATA_W in [-MAX, +MAX].
REQ-017 Square: c = +MAX if P MSB = 0, else -MAX.
REQ-018 Triangle: t = P MSB ? ~P[DATA_W-2:0] : P[DATA_W-2:0]; c = 2*t - MAX.
REQ-019 Sawtooth: c = P - 2^(DATA_W-1) as signed; -2^(DATA_W-1) clamped to -MAX.
REQ-020 Stage 1 (cycle of in_valid=1): SHALL register pcm_in, c from the current ph value (pre-update), mode, enable, mix.
REQ-021 Stage 2: wet = (x * c) >>> (DATA_W-1), 2*DATA_W-bit signed product, arithmetic shift (floor); wet = x when mode=11 or enable=0.
REQ-022 wet SHALL never overflow DATA_W because |c| <= MAX; no saturation logic required.
REQ-023 Stage 3: w = (mix all-ones) ? 2^MIX_W : mix; pcm_out = (wet*w + x*(2^MIX_W - w)) >>> MIX_W, floor rounding.
REQ-024 mix = 0 SHALL yield pcm_out == pcm_in bit-exact in every mode.
REQ-025 Latency SHALL be exactly 3 cycles: in_valid at cycle N -> out_valid and pcm_out at cycle N+3, pcm_out registered.
REQ-026 Back-to-back in_valid SHALL be accepted every cycle with throughput 1 sample/clk.
REQ-027 mode, mix, enable, phase_inc changes SHALL affect only samples accepted on or after the change cycle; in-flight samples use stage-1 captured values.
REQ-028 phase_inc = 0 SHALL freeze the carrier at its current value.
REQ-029 Cycles with in_valid=0 SHALL insert bubbles; out_valid SHALL be 0 for corresponding output cycles.

Reset
REQ-030 rst=1 SHALL force ph=0, all pipeline valid bits=0, out_valid=0, pcm_out=0 on the next edge.
REQ-031 rst SHALL dominate in_valid; samples in flight or presented during reset SHALL be discarded and never produce out_valid.
REQ-032 After rst deasserts, first accepted sample SHALL see ph=0 if enable was 1 for no intervening cycle.

Verification (DATA_W=16, PHASE_W=24, MIX_W=8)
REQ-033 Reset: rst high 2 cycles -> out_valid=0, pcm_out=0x0000, ph=0.
REQ-034 Square, phase_inc=0, mix=0xFF, enable=1, pcm_in=16384 right after reset -> pcm_out=16383 exactly 3 cycles later, one out_valid pulse.
REQ-035 Square, phase_inc=0x800000, pcm_in=-32768 on two consecutive cycles from ph=0 -> outputs -32767 then +32767 on consecutive cycles.
REQ-036 Square, phase_inc=0, mix=0x80, pcm_in=1000 -> pcm_out=999; mix=0x00 any mode, pcm_in=-12345 -> pcm_out=-12345.
REQ-037 enable=0, mode=01, mix=0xFF, pcm_in=500 -> pcm_out=500 after 3 cycles; ph unchanged across the disabled interval.
REQ-038 Two samples in flight, rst asserted 1 cycle -> no out_valid for either; next sample after release emerges with 3-cycle latency.

Source files
------------

// File: rtl/multimode_ring_mod.sv
// Ring modulator with square/triangle/sawtooth carrier and wet/dry mix.
// Three-stage pipeline: capture + carrier, modulate, mix; out_valid follows in_valid by 3 clocks.
module multimode_ring_mod #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 24,
    parameter int MIX_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [MIX_W-1:0]   mix,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  pcm_in,
    output logic               out_valid,
    output logic [DATA_W-1:0]  pcm_out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = DATA_W + MIX_W + 2;

    localparam logic signed [DATA_W-1:0] C_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] C_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
    localparam logic [MIX_W:0]           W_FULL = {1'b1, {MIX_W{1'b0}}};

    logic [PHASE_W-1:0] ph_q, ph_d;

    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_x_q, s1_x_d;
    logic signed [DATA_W-1:0] s1_c_q, s1_c_d;
    logic                     s1_bypass_q, s1_bypass_d;
    logic [MIX_W-1:0]         s1_mix_q;

    logic                     s2_valid_q;
    logic signed [DATA_W-1:0] s2_x_q;
    logic signed [DATA_W-1:0] s2_wet_q, s2_wet_d;
    logic [MIX_W-1:0]         s2_mix_q;

    logic                     out_valid_q;
    logic [DATA_W-1:0]        pcm_out_q, pcm_out_d;

    logic [DATA_W-1:0]        phase_top;
    logic [DATA_W-2:0]        tri_t;
    logic signed [PROD_W-1:0] prod;
    logic [MIX_W:0]           w, inv_w;
    logic signed [ACC_W-1:0]  wet_ext, x_ext, w_ext, inv_w_ext, acc;

    always_comb begin
        ph_d = enable ? ph_q + phase_inc : ph_q;
    end

    // Carrier is derived from the pre-update phase of the capture cycle.
    always_comb begin
        phase_top = ph_q[PHASE_W-1 -: DATA_W];
        tri_t     = phase_top[DATA_W-1] ? ~phase_top[DATA_W-2:0] : phase_top[DATA_W-2:0];
        case (mode)
            2'b00:   s1_c_d = phase_top[DATA_W-1] ? C_NEG : C_MAX;
            2'b01:   s1_c_d = {tri_t, 1'b0} - C_MAX;
            2'b10:   s1_c_d = (phase_top == '0) ? C_NEG
                                                : {~phase_top[DATA_W-1], phase_top[DATA_W-2:0]};
            default: s1_c_d = C_MAX;
        endcase
        s1_x_d      = pcm_in;
        s1_bypass_d = (mode == 2'b11) || !enable;
    end

    // |c| <= MAX keeps the shifted product inside DATA_W, so plain truncation is safe.
    always_comb begin
        prod     = PROD_W'(s1_x_q) * PROD_W'(s1_c_q);
        s2_wet_d = s1_bypass_q ? s1_x_q : DATA_W'(prod >>> (DATA_W - 1));
    end

    always_comb begin
        w         = (&s2_mix_q) ? W_FULL : {1'b0, s2_mix_q};
        inv_w     = W_FULL - w;
        wet_ext   = ACC_W'(s2_wet_q);
        x_ext     = ACC_W'(s2_x_q);
        w_ext     = ACC_W'(w);
        inv_w_ext = ACC_W'(inv_w);
        acc       = wet_ext * w_ext + x_ext * inv_w_ext;
        pcm_out_d = DATA_W'(acc >>> MIX_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_c_q      <= '0;
            s1_bypass_q <= 1'b0;
            s1_mix_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_wet_q    <= '0;
            s2_mix_q    <= '0;
            out_valid_q <= 1'b0;
            pcm_out_q   <= '0;
        end else begin
            ph_q       <= ph_d;
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_x_q      <= s1_x_d;
                s1_c_q      <= s1_c_d;
                s1_bypass_q <= s1_bypass_d;
                s1_mix_q    <= mix;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_x_q   <= s1_x_q;
                s2_wet_q <= s2_wet_d;
                s2_mix_q <= s1_mix_q;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                pcm_out_q <= pcm_out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign pcm_out   = pcm_out_q;

endmodule
